// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: Execute-stage handshake between the pipeline and the
// iterative multiply/divide sequencer.
//   StartE    valid M-type op in Execute this cycle        (pipeline -> seq)
//   MdOpE     00 MUL, 01 MULHU, 10 DIVU, 11 REMU           (pipeline -> seq)
//   SrcAE     operand A, multiplicand/dividend             (pipeline -> seq)
//   SrcBE     operand B, multiplier/divisor                (pipeline -> seq)
//   FlushE    kill the instruction in Execute              (pipeline -> seq)
//   StallMD   hold F/D/E, bubble into Ex_Mem               (seq -> pipeline)
//   MdDoneE   one-cycle pulse, MdResultE valid             (seq -> pipeline)
//   MdResultE selected result                              (seq -> pipeline)
//   BusyMD    sequencer is iterating                       (seq -> pipeline)
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             StartE;
    logic [1:0]       MdOpE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             FlushE;
    logic             StallMD;
    logic             MdDoneE;
    logic [WIDTH-1:0] MdResultE;
    logic             BusyMD;

    modport master (
        output StartE, MdOpE, SrcAE, SrcBE, FlushE,
        input  StallMD, MdDoneE, MdResultE, BusyMD
    );

    modport slave (
        input  StartE, MdOpE, SrcAE, SrcBE, FlushE,
        output StallMD, MdDoneE, MdResultE, BusyMD
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned multiply/divide beside the Execute ALU.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over
// WIDTH cycles, stalling the pipeline while running and presenting a
// registered result with a one-cycle MdDoneE pulse.
// Ports:
//   clk    pipeline clock
//   reset  asynchronous, active-high reset
//   md     muldiv_seq_if slave modport (see interface for signal list)
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_seq_if.slave   md
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;

    // multiply datapath
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // divide datapath: dvd shifts the dividend out of its MSB while the
    // quotient bits shift in at the LSB, so it ends holding the quotient
    logic [WIDTH-1:0]   dvd, dvd_nxt;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   rem, rem_nxt;
    logic [WIDTH:0]     shifted, trial;

    logic [WIDTH-1:0]   result, result_nxt;
    logic               stall, start, last_iter;

    // one iteration of both algorithms; the op only selects the result
    always_comb begin
        acc_nxt = mplier[0] ? acc + mcand : acc;
        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        // borrow out (trial MSB) means shifted < divisor: restore.
        // Divisor 0 never borrows, giving all-ones quotient and
        // remainder = dividend without a special case.
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            dvd_nxt = {dvd[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
        end
        case (op_q)
            2'b00:   result_nxt = acc_nxt[WIDTH-1:0];
            2'b01:   result_nxt = acc_nxt[2*WIDTH-1:WIDTH];
            2'b10:   result_nxt = dvd_nxt;
            default: result_nxt = rem_nxt;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        start     = 1'b0;
        last_iter = 1'b0;
        case (state)
            IDLE: begin
                if (md.StartE && !md.FlushE) begin
                    start     = 1'b1;
                    stall     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                stall = 1'b1;
                if (md.FlushE) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    last_iter = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            dvd     <= '0;
            divisor <= '0;
            rem     <= '0;
            result  <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                cnt     <= '0;
                op_q    <= md.MdOpE;
                acc     <= '0;
                mcand   <= {{WIDTH{1'b0}}, md.SrcAE};
                mplier  <= md.SrcBE;
                dvd     <= md.SrcAE;
                divisor <= md.SrcBE;
                rem     <= '0;
            end else if (state == RUN) begin
                cnt    <= cnt + CW'(1);
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                dvd    <= dvd_nxt;
                rem    <= rem_nxt;
            end
            if (last_iter) begin
                result <= result_nxt;
            end
        end
    end

    assign md.StallMD   = stall;
    assign md.BusyMD    = (state == RUN);
    assign md.MdDoneE   = (state == DONE);
    assign md.MdResultE = result;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed self-checking bench for muldiv_seq
// against a plain-arithmetic reference model.
module tb_muldiv_seq;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_pulses = 0;
    logic [W-1:0] last_res;

    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(W)) mif ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    always @(posedge clk) cyc++;
    always @(negedge clk) if (mif.MdDoneE === 1'b1) done_pulses++;

    function automatic logic [W-1:0] ref_md(input logic [1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issues one op at the next falling edge and follows it to MdDoneE.
    // Returns with time just after the falling edge of the DONE cycle.
    // done_at = -1 means no pulse within the cycle budget.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit scramble,
                         output logic [W-1:0] res, output int stall_n,
                         output int done_at, output int done_abs);
        @(negedge clk);
        mif.StartE = 1'b1;
        mif.FlushE = 1'b0;
        mif.MdOpE  = op;
        mif.SrcAE  = a;
        mif.SrcBE  = b;
        stall_n  = 0;
        done_at  = -1;
        done_abs = -1;
        res      = 'x;
        for (int i = 0; i < 3 * W; i++) begin
            #1;
            if (mif.MdDoneE === 1'b1) begin
                done_at  = i;
                done_abs = cyc;
                res      = mif.MdResultE;
                break;
            end
            if (mif.StallMD === 1'b1) stall_n++;
            @(negedge clk);
            if (scramble) begin
                mif.SrcAE = $urandom;
                mif.SrcBE = $urandom;
                mif.MdOpE = 2'($urandom);
            end
        end
        mif.StartE = 1'b0;
    endtask

    task automatic test_reset();
        mif.StartE = 1'b0;
        mif.FlushE = 1'b0;
        mif.MdOpE  = '0;
        mif.SrcAE  = '0;
        mif.SrcBE  = '0;
        reset = 1'b1;
        #12;
        checks++; if (mif.StallMD !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", mif.StallMD); end
        checks++; if (mif.MdDoneE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", mif.MdDoneE); end
        checks++; if (mif.BusyMD !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mif.BusyMD); end
        checks++; if (mif.MdResultE !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", mif.MdResultE); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul_basic();
        logic [W-1:0] r;
        int sn, da, dabs;
        do_op(2'b00, 7, 6, 1'b0, r, sn, da, dabs);
        checks++; if (r !== 42) begin failures++; $display("FAIL mul7x6 got=%0d exp=42", r); end
        checks++; if (sn !== W + 1) begin failures++; $display("FAIL mul_stall_cycles got=%0d exp=%0d", sn, W + 1); end
        checks++; if (da !== W + 1) begin failures++; $display("FAIL mul_done_cycle got=%0d exp=%0d", da, W + 1); end
        checks++; if (mif.StallMD !== 1'b0) begin failures++; $display("FAIL done_stall got=%b exp=0", mif.StallMD); end
        @(negedge clk); #1;
        checks++; if (mif.MdDoneE !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", mif.MdDoneE); end
        checks++; if (mif.MdResultE !== 42) begin failures++; $display("FAIL result_hold got=%0d exp=42", mif.MdResultE); end
        last_res = 42;
    endtask

    task automatic test_directed();
        logic [1:0]   ops[6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
        logic [W-1:0] as[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 100, 100, 5, 5};
        logic [W-1:0] bs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 7, 0, 0};
        logic [W-1:0] ex[6]  = '{32'hFFFF_FFFE, 32'h0000_0001, 14, 2, 32'hFFFF_FFFF, 5};
        logic [W-1:0] r;
        int sn, da, dabs;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b0, r, sn, da, dabs);
            checks++;
            if (r !== ex[i] || da !== W + 1) begin
                failures++;
                $display("FAIL directed_%0d op=%0d a=%h b=%h got=%h@%0d exp=%h@%0d",
                         i, ops[i], as[i], bs[i], r, da, ex[i], W + 1);
            end
            last_res = ex[i];
        end
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] a, b, r, e;
        int sn, da, dabs;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 0;
                1:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            e = ref_md(op, a, b);
            do_op(op, a, b, 1'b1, r, sn, da, dabs);
            checks++;
            if (r !== e || da !== W + 1 || sn !== W + 1) begin
                failures++;
                $display("FAIL random_%0d op=%0d a=%h b=%h got=%h done@%0d stall=%0d exp=%h done@%0d stall=%0d",
                         i, op, a, b, r, da, sn, e, W + 1, W + 1);
            end
            last_res = e;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r1, r2;
        int sn1, da1, ab1, sn2, da2, ab2, p0;
        p0 = done_pulses;
        do_op(2'b10, 32'h8000_0000, 2, 1'b0, r1, sn1, da1, ab1);
        do_op(2'b00, 3, 3, 1'b0, r2, sn2, da2, ab2);
        checks++; if (r1 !== 32'h4000_0000) begin failures++; $display("FAIL b2b_divu got=%h exp=40000000", r1); end
        checks++; if (r2 !== 9) begin failures++; $display("FAIL b2b_mul got=%0d exp=9", r2); end
        checks++; if (ab2 - ab1 !== W + 2) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", ab2 - ab1, W + 2); end
        checks++; if (sn2 !== W + 1) begin failures++; $display("FAIL b2b_second_stall got=%0d exp=%0d", sn2, W + 1); end
        @(negedge clk); #1;
        checks++; if (done_pulses - p0 !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", done_pulses - p0); end
        last_res = 9;
    endtask

    task automatic test_flush_run();
        int p0;
        p0 = done_pulses;
        @(negedge clk);
        mif.StartE = 1'b1; mif.FlushE = 1'b0; mif.MdOpE = 2'b00;
        mif.SrcAE = 123; mif.SrcBE = 456;
        // cycle T is the start cycle; counter reaches 10 in cycle T+11
        for (int i = 0; i < 11; i++) @(negedge clk);
        mif.FlushE = 1'b1;
        mif.StartE = 1'b0;
        #1;
        checks++; if (mif.StallMD !== 1'b1 || mif.BusyMD !== 1'b1) begin failures++; $display("FAIL flush_cycle stall=%b busy=%b exp=1,1", mif.StallMD, mif.BusyMD); end
        @(negedge clk);
        mif.FlushE = 1'b0;
        #1;
        checks++; if (mif.StallMD !== 1'b0 || mif.BusyMD !== 1'b0) begin failures++; $display("FAIL flush_idle stall=%b busy=%b exp=0,0", mif.StallMD, mif.BusyMD); end
        for (int i = 0; i < W + 8; i++) @(negedge clk);
        #1;
        checks++; if (done_pulses !== p0) begin failures++; $display("FAIL flush_no_done pulses=%0d exp=%0d", done_pulses - p0, 0); end
        checks++; if (mif.MdResultE !== last_res) begin failures++; $display("FAIL flush_result_kept got=%h exp=%h", mif.MdResultE, last_res); end
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        mif.StartE = 1'b1; mif.FlushE = 1'b1; mif.MdOpE = 2'b10;
        mif.SrcAE = 77; mif.SrcBE = 3;
        #1;
        checks++; if (mif.StallMD !== 1'b0) begin failures++; $display("FAIL flush_start_stall got=%b exp=0", mif.StallMD); end
        @(negedge clk);
        mif.StartE = 1'b0; mif.FlushE = 1'b0;
        #1;
        checks++; if (mif.BusyMD !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b exp=0", mif.BusyMD); end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] r;
        int sn, da, dabs;
        @(negedge clk);
        mif.StartE = 1'b1; mif.FlushE = 1'b0; mif.MdOpE = 2'b10;
        mif.SrcAE = 1000; mif.SrcBE = 9;
        for (int i = 0; i < 6; i++) @(negedge clk);
        #2;
        reset = 1'b1;
        mif.StartE = 1'b0;
        #1;
        checks++;
        if (mif.StallMD !== 1'b0 || mif.BusyMD !== 1'b0 || mif.MdDoneE !== 1'b0 || mif.MdResultE !== '0) begin
            failures++;
            $display("FAIL async_reset stall=%b busy=%b done=%b res=%h exp=0,0,0,0",
                     mif.StallMD, mif.BusyMD, mif.MdDoneE, mif.MdResultE);
        end
        @(negedge clk);
        reset = 1'b0;
        do_op(2'b00, 2, 3, 1'b0, r, sn, da, dabs);
        checks++; if (r !== 6 || da !== W + 1) begin failures++; $display("FAIL post_reset_mul got=%0d@%0d exp=6@%0d", r, da, W + 1); end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush_run();
        test_flush_idle();
        test_reset_mid_run();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer beside the Execute-stage ALU.
- Accepts one unsigned M-type op from Execute and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- Holds the pipeline with a stall request while running, then presents the result for one cycle so it can be muxed into ALUResultE ahead of Ex_Mem.

Parameters:
WIDTH, 32, operand/result width; also the number of RUN iterations.

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-high reset
StartE  input  1  valid M-type op present in Execute this cycle
MdOpE  input  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU, 11 REMU
SrcAE  input  WIDTH  operand A (multiplicand/dividend), post-forwarding
SrcBE  input  WIDTH  operand B (multiplier/divisor), post-forwarding
FlushE  input  1  kill the instruction in Execute (branch/jump taken)
StallMD  output  1  hold Fetch/Decode/Execute registers and insert a bubble into Ex_Mem
MdDoneE  output  1  one-cycle pulse: MdResultE valid this cycle
MdResultE  output  WIDTH  selected result
BusyMD  output  1  state is RUN

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset state:
  - state=IDLE; StallMD=0, MdDoneE=0, BusyMD=0, MdResultE=0.
  - Internal operand, accumulator and counter registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - StartE=1 and FlushE=0: latch SrcAE, SrcBE and MdOpE; counter=0; next state RUN.
  - StallMD = StartE & ~FlushE (combinational), so Execute holds its operands from the start cycle.
  - FlushE=1 overrides StartE: no start, StallMD=0.
- RUN:
  - StallMD=1, BusyMD=1.
  - One iteration per cycle; counter increments 0..WIDTH-1. At counter=WIDTH-1, next state DONE.
  - Operands are not re-sampled during RUN; input changes are ignored.
- Multiply:
  - 2*WIDTH-bit product register; each iteration adds the multiplicand if the current multiplier LSB is 1, then shifts.
  - MUL returns bits [WIDTH-1:0]; MULHU returns bits [2*WIDTH-1:WIDTH].
- Divide:
  - Restoring divide; remainder register is WIDTH+1 bits. Each iteration shifts in the next dividend bit and subtracts the divisor; a quotient bit of 1 is kept if the result is non-negative, otherwise the remainder is restored.
  - DIVU returns the quotient; REMU returns the remainder.
  - Divide by zero: quotient=all ones, remainder=dividend (RISC-V semantics); the natural algorithm output must match this.
- DONE:
  - StallMD=0, MdDoneE=1 for exactly this cycle; MdResultE is registered and stable.
  - Pipeline advances this cycle; next state IDLE unconditionally.
  - StartE seen during DONE is the retiring instruction and is ignored.
- MdResultE holds its value after DONE until the next DONE or reset.
- Latency: start cycle T (IDLE), RUN for T+1..T+WIDTH, DONE at T+WIDTH+1. StallMD is high for WIDTH+1 cycles (T..T+WIDTH).
- Back-to-back ops: the next op arrives in Execute at T+WIDTH+2 with state IDLE and starts normally. No extra bubble is required beyond that.
- FlushE during RUN: next state IDLE, no MdDoneE, MdResultE unchanged, StallMD drops the following cycle.
- FlushE during DONE: MdDoneE still pulses; the pipeline is responsible for discarding the result.
- reset mid-RUN: immediate return to the reset state; no MdDoneE.
- Width rules:
  - All arithmetic is unsigned.
  - Product register is 2*WIDTH bits with no overflow loss.
  - Counter width is clog2(WIDTH)+1.

Test Plan:
- MUL 7 x 6 (StartE=1, MdOpE=00) -> StallMD high 33 cycles; MdDoneE pulse at cycle 33; MdResultE=42.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> MdResultE=0xFFFFFFFE. The same operands with MUL -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- Back-to-back DIVU 0x80000000/2 then MUL 3 x 3 -> 0x40000000 then 9.
  - MdDoneE pulses 34 cycles apart.
  - No lost or duplicated pulse; StallMD low exactly one cycle between the two ops.
- FlushE asserted in RUN at counter=10 -> IDLE next cycle; no MdDoneE; MdResultE retains its prior value. FlushE with StartE in IDLE -> no start, StallMD=0.
- reset asserted asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately. After release, a new MUL 2 x 3 returns 6 with normal latency.
